// File: rtl/sprite_mixer.sv
// sprite_mixer: composites up to NSPR sprite pixels over a background through a
// per-sprite palette with a fixed 2-cycle latency, and accumulates pairwise collisions per frame.
module sprite_mixer #(
    parameter int NSPR      = 4,
    parameter int SPR_DATAW = 3,
    parameter int COLRW     = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame,
    input  logic                               de,
    input  logic [NSPR-1:0]                    spr_drawing,
    input  logic [NSPR*SPR_DATAW-1:0]          spr_pix,
    input  logic [COLRW-1:0]                   bg_colr,
    input  logic                               pal_we,
    input  logic [$clog2(NSPR)+SPR_DATAW-1:0]  pal_addr,
    input  logic [COLRW-1:0]                   pal_wdata,
    output logic [COLRW-1:0]                   colr,
    output logic                               colr_de,
    output logic [NSPR*(NSPR-1)/2-1:0]         coll,
    output logic                               coll_valid
);
    localparam int SW    = $clog2(NSPR);
    localparam int AW    = SW + SPR_DATAW;
    localparam int NPAIR = NSPR * (NSPR - 1) / 2;

    logic [NSPR-1:0]      opaque;
    logic [NPAIR-1:0]     hits;
    logic [SW-1:0]        win_spr;
    logic [SPR_DATAW-1:0] win_pix;
    logic                 win_any;

    logic [COLRW-1:0]     pal_mem [2**AW];

    logic [COLRW-1:0]     pal_rd_d, pal_rd_q;
    logic [COLRW-1:0]     bg_d, bg_q;
    logic                 bg_sel_d, bg_sel_q;
    logic                 de1_d, de1_q;
    logic [COLRW-1:0]     colr_d, colr_q;
    logic                 colr_de_d, colr_de_q;
    logic [NPAIR-1:0]     acc_d, acc_q;
    logic [NPAIR-1:0]     coll_d, coll_q;
    logic                 coll_valid_d, coll_valid_q;

    for (genvar gi = 0; gi < NSPR; gi++) begin : g_opaque
        assign opaque[gi] = spr_drawing[gi] && (spr_pix[gi*SPR_DATAW +: SPR_DATAW] != '0);
    end

    // Pair (i,j), i<j, maps row-major onto hits[i*NSPR - i*(i+1)/2 + j-i-1].
    for (genvar gi = 0; gi < NSPR; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NSPR; gj++) begin : g_col
            assign hits[gi*NSPR - gi*(gi+1)/2 + gj - gi - 1] = de && opaque[gi] && opaque[gj];
        end
    end

    always_comb begin
        win_spr = '0;
        win_pix = '0;
        win_any = 1'b0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_spr = SW'(i);
                win_pix = spr_pix[i*SPR_DATAW +: SPR_DATAW];
                win_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
    end

    // The palette address is captured on the stage-1 edge, so a write on that
    // same edge is not seen by this read (read-before-write).
    always_comb begin
        pal_rd_d     = pal_mem[{win_spr, win_pix}];
        bg_d         = bg_colr;
        bg_sel_d     = !win_any;
        de1_d        = de;
        colr_d       = de1_q ? (bg_sel_q ? bg_q : pal_rd_q) : '0;
        colr_de_d    = de1_q;
        acc_d        = frame ? '0 : (acc_q | hits);
        coll_d       = frame ? (acc_q | hits) : coll_q;
        coll_valid_d = frame;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pal_rd_q     <= '0;
            bg_q         <= '0;
            bg_sel_q     <= 1'b0;
            de1_q        <= 1'b0;
            colr_q       <= '0;
            colr_de_q    <= 1'b0;
            acc_q        <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            pal_rd_q     <= pal_rd_d;
            bg_q         <= bg_d;
            bg_sel_q     <= bg_sel_d;
            de1_q        <= de1_d;
            colr_q       <= colr_d;
            colr_de_q    <= colr_de_d;
            acc_q        <= acc_d;
            coll_q       <= coll_d;
            coll_valid_q <= coll_valid_d;
        end
    end

    assign colr       = colr_q;
    assign colr_de    = colr_de_q;
    assign coll       = coll_q;
    assign coll_valid = coll_valid_q;

endmodule
